// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the omega8 instruction fetch unit: FSM state
// encoding, the NOP word presented when nothing is valid, and default widths.
package instr_fetch_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 30;

  // Word shown on the decoder side whenever the prefetch FIFO is empty.
  localparam logic [29:0] INSTR_NOP = 30'h3FFFFFFF;

  // Fetch FSM encoding.
  //   S_IDLE : no request outstanding
  //   S_REQ  : read held until memory signals done, response is kept
  //   S_DROP : read held until done, response thrown away (stale after redirect)
  //   S_ERR  : halted after a memory timeout, left only by reset or redirect
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding {pc, instr} pairs between the
// memory response and the decoder. Flush empties it in one edge.
// Head outputs are registered storage only, so no input-to-head
// combinational path exists.
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 16,
  parameter int DATA_W = 30,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_push_pc,
  input  logic [DATA_W-1:0] i_push_data,
  output logic [PC_W-1:0]   o_head_pc,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W+DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write; the caller never pushes into a full FIFO.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= {i_push_pc, i_push_data};
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign {o_head_pc, o_head_data} = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter plus instruction-memory read initiator for
// the omega8 core. Responses go into fetch_fifo, which feeds the decoder.
// Decoder handshake: the head transfers on a cycle where o_fetch_valid and
// i_fetch_ready are both high; o_fetch_valid never depends on i_fetch_ready.
// Memory handshake: o_instr_read/o_instr_addr are held stable from the first
// request cycle up to and including the cycle where i_instr_read_done is high.
// Optional feature: define INSTR_FETCH_TIMEOUT_EN to build the read timeout
// (S_ERR + sticky o_fetch_err); otherwise the unit waits forever for done.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W         = DEF_ADDR_W,
  parameter int                INSTR_W        = DEF_INSTR_W,
  parameter int                BUF_DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_instr_addr,
  output logic               o_instr_read,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_instr_read_done,
  output logic [INSTR_W-1:0] o_fetch_instr,
  output logic [ADDR_W-1:0]  o_fetch_pc,
  output logic               o_fetch_valid,
  input  logic               i_fetch_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_fetch_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ADDR_W-1:0]  r_pc;         // next address to fetch (redirect target while dropping)
  logic [ADDR_W-1:0]  r_drop_addr;  // stale address kept on the bus while dropping
  logic               w_read;
  logic               w_push;
  logic               w_pop;
  logic               w_room;
  logic               w_timeout;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_next;
  logic [ADDR_W-1:0]  w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;

  assign w_read       = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_push       = (r_state == S_REQ) && i_instr_read_done && !i_redirect;
  assign w_pop        = !w_fifo_empty && i_fetch_ready && !i_redirect;
  assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_room       = (w_count_next < CNT_W'(BUF_DEPTH));

  fetch_fifo #(
    .DEPTH  (BUF_DEPTH),
    .PC_W   (ADDR_W),
    .DATA_W (INSTR_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .i_push_pc   (r_pc),
    .i_push_data (i_instr),
    .o_head_pc   (w_head_pc),
    .o_head_data (w_head_instr),
    .o_count     (w_count),
    .o_empty     (w_fifo_empty)
  );

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = w_read && !i_instr_read_done &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive waiting cycles; any completion, idle or redirect restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (i_redirect || !w_read || i_instr_read_done || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset or redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           r_err <= 1'b0;
    else if (i_redirect) r_err <= 1'b0;
    else if (w_timeout)  r_err <= 1'b1;
  end

  assign o_fetch_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
  assign o_fetch_err      = 1'b0;
`endif

  // Next-state logic; redirect overrides everything else.
  always_comb begin
    w_state_next = r_state;
    if (i_redirect) begin
      w_state_next = (w_read && !i_instr_read_done) ? S_DROP : S_REQ;
    end else begin
      case (r_state)
        S_IDLE:  if (w_room) w_state_next = S_REQ;
        S_REQ:   begin
          if (w_timeout)                           w_state_next = S_ERR;
          else if (i_instr_read_done && !w_room)   w_state_next = S_IDLE;
        end
        S_DROP:  begin
          if (w_timeout)              w_state_next = S_ERR;
          else if (i_instr_read_done) w_state_next = S_REQ;
        end
        S_ERR:   w_state_next = S_ERR;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State, PC and held stale address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (i_redirect) begin
        r_pc <= i_redirect_pc;
        // Only a fresh outstanding read needs its address remembered; in
        // S_DROP the stale address is already captured.
        if (r_state == S_REQ && !i_instr_read_done) r_drop_addr <= r_pc;
      end else if (w_push) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  assign o_instr_read  = w_read;
  assign o_instr_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign o_fetch_valid = !w_fifo_empty;
  assign o_fetch_pc    = w_head_pc;
  assign o_fetch_instr = w_fifo_empty ? INSTR_W'(INSTR_NOP) : w_head_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: behavioural instruction memory with wait states,
// expected-PC scoreboard for the decoder stream, directed and random scenarios.
module tb_instr_fetch;

  localparam int          AW    = 16;
  localparam int          IW    = 30;
  localparam int          DEPTH = 2;
  localparam logic [IW-1:0] NOP = 30'h3FFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] instr_addr;
  logic          instr_read;
  logic [IW-1:0] mem_data;
  logic          mem_done;
  logic [IW-1:0] fetch_instr;
  logic [AW-1:0] fetch_pc;
  logic          fetch_valid;
  logic          fetch_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          fetch_err;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_q[$];
  logic [IW-1:0] prog_rom [16];
  int            wait_n   = 0;
  bit            hang     = 1'b0;
  int            wait_cnt = 0;
  int            push_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  instr_fetch #(
    .ADDR_W         (AW),
    .INSTR_W        (IW),
    .BUF_DEPTH      (DEPTH),
    .RESET_PC       (16'd0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_instr_addr      (instr_addr),
    .o_instr_read      (instr_read),
    .i_instr           (mem_data),
    .i_instr_read_done (mem_done),
    .o_fetch_instr     (fetch_instr),
    .o_fetch_pc        (fetch_pc),
    .o_fetch_valid     (fetch_valid),
    .i_fetch_ready     (fetch_ready),
    .i_redirect        (redirect),
    .i_redirect_pc     (redirect_pc),
    .o_fetch_err       (fetch_err)
  );

  // Behavioural instruction memory: fib program at 0..15, NOP elsewhere.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a < 16) return prog_rom[a[3:0]];
    return NOP;
  endfunction

  assign mem_data = mem_word(instr_addr);
  assign mem_done = instr_read && !hang && (wait_cnt >= wait_n);

  always @(posedge clk) begin
    if (instr_read && !mem_done) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end

  // Scoreboard: every accepted head must be the next expected PC with its word.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (!rst) begin
      if (instr_read && mem_done) push_cnt++;
      if (fetch_valid && fetch_ready && !redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got pc=%h with nothing expected", fetch_pc);
        end else begin
          e = exp_q.pop_front();
          if (fetch_pc !== e || fetch_instr !== mem_word(e)) begin
            failures++;
            $display("FAIL sb_head got pc=%h instr=%h exp pc=%h instr=%h",
                     fetch_pc, fetch_instr, e, mem_word(e));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_exp(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + AW'(i));
  endtask

  task automatic do_reset(input logic rdy);
    rst         = 1'b1;
    redirect    = 1'b0;
    fetch_ready = rdy;
    hang        = 1'b0;
    repeat (2) tick;
    fill_exp(16'd0);
    push_cnt = 0;
    rst      = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    checks++;
    if (instr_read !== 1'b0) begin
      failures++; $display("FAIL reset_read got=%b exp=0", instr_read);
    end
    checks++;
    if (fetch_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", fetch_valid);
    end
    checks++;
    if (fetch_err !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", fetch_err);
    end
    checks++;
    if (instr_addr !== 16'd0) begin
      failures++; $display("FAIL reset_addr got=%h exp=0000", instr_addr);
    end
    checks++;
    if (fetch_instr !== NOP) begin
      failures++; $display("FAIL reset_instr got=%h exp=%h", fetch_instr, NOP);
    end
  endtask

  task automatic test_stream;
    wait_n = 0;
    do_reset(1'b1);
    tick;
    checks++;
    if (instr_read !== 1'b1 || instr_addr !== 16'd0) begin
      failures++; $display("FAIL stream_first_read got read=%b addr=%h exp read=1 addr=0000", instr_read, instr_addr);
    end
    tick;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'd0 || fetch_instr !== 30'd6) begin
      failures++; $display("FAIL stream_first_head got v=%b pc=%h instr=%h exp v=1 pc=0000 instr=6", fetch_valid, fetch_pc, fetch_instr);
    end
    for (int c = 3; c <= 20; c++) begin
      tick;
      checks++;
      if (fetch_valid !== 1'b1 || instr_addr !== AW'(c - 1)) begin
        failures++; $display("FAIL stream_rate cycle=%0d got v=%b addr=%h exp v=1 addr=%h", c, fetch_valid, instr_addr, AW'(c - 1));
      end
    end
  endtask

  task automatic test_backpressure;
    wait_n = 0;
    do_reset(1'b0);
    repeat (10) tick;
    checks++;
    if (push_cnt !== DEPTH) begin
      failures++; $display("FAIL bp_fetched got=%0d exp=%0d", push_cnt, DEPTH);
    end
    checks++;
    if (instr_read !== 1'b0) begin
      failures++; $display("FAIL bp_read_drop got=%b exp=0", instr_read);
    end
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'd0) begin
      failures++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0000", fetch_valid, fetch_pc);
    end
    fetch_ready = 1'b1;
    tick;
    checks++;
    if (instr_read !== 1'b1 || instr_addr !== 16'd2) begin
      failures++; $display("FAIL bp_reassert got read=%b addr=%h exp read=1 addr=0002", instr_read, instr_addr);
    end
    repeat (10) tick;
    checks++;
    if (fetch_valid !== 1'b1) begin
      failures++; $display("FAIL bp_resume got v=%b exp=1", fetch_valid);
    end
  endtask

  task automatic test_wait_states;
    logic          pw;
    logic [AW-1:0] pa;
    wait_n = 3;
    do_reset(1'b1);
    repeat (4) tick;
    push_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      pw = instr_read && !mem_done;
      pa = instr_addr;
      tick;
      if (pw) begin
        checks++;
        if (instr_read !== 1'b1 || instr_addr !== pa) begin
          failures++; $display("FAIL ws_hold got read=%b addr=%h exp read=1 addr=%h", instr_read, instr_addr, pa);
        end
      end
    end
    checks++;
    if (push_cnt !== 10) begin
      failures++; $display("FAIL ws_throughput got=%0d exp=10", push_cnt);
    end
  endtask

  task automatic test_redirect_drop;
    int n;
    wait_n = 3;
    do_reset(1'b1);
    n = 0;
    while (!(instr_read && instr_addr == 16'd3 && wait_cnt == 0) && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++; $display("FAIL drop_find got no read of addr 3 exp one within 40 cycles");
    end
    redirect    = 1'b1;
    redirect_pc = 16'd8;
    fill_exp(16'd8);
    tick;
    redirect = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instr_read !== 1'b1 || instr_addr !== 16'd3) begin
      failures++; $display("FAIL drop_flush got v=%b read=%b addr=%h exp v=0 read=1 addr=0003", fetch_valid, instr_read, instr_addr);
    end
    n = 0;
    while (!mem_done && n < 10) begin
      tick;
      n++;
      checks++;
      if (instr_read !== 1'b1 || instr_addr !== 16'd3) begin
        failures++; $display("FAIL drop_hold got read=%b addr=%h exp read=1 addr=0003", instr_read, instr_addr);
      end
    end
    checks++;
    if (n >= 10) begin
      failures++; $display("FAIL drop_done got no done exp done within 10 cycles");
    end
    tick;
    checks++;
    if (instr_read !== 1'b1 || instr_addr !== 16'd8 || fetch_valid !== 1'b0) begin
      failures++; $display("FAIL drop_restart got read=%b addr=%h v=%b exp read=1 addr=0008 v=0", instr_read, instr_addr, fetch_valid);
    end
    n = 0;
    while (!fetch_valid && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'd8 || fetch_instr !== mem_word(16'd8)) begin
      failures++; $display("FAIL drop_head got v=%b pc=%h exp v=1 pc=0008", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_redirect_done_pop;
    wait_n = 0;
    do_reset(1'b1);
    repeat (6) tick;
    checks++;
    if (!(mem_done && fetch_valid)) begin
      failures++; $display("FAIL rdp_setup got done=%b v=%b exp done=1 v=1", mem_done, fetch_valid);
    end
    redirect    = 1'b1;
    redirect_pc = 16'd12;
    fill_exp(16'd12);
    tick;
    redirect = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || instr_read !== 1'b1 || instr_addr !== 16'd12) begin
      failures++; $display("FAIL rdp_flush got v=%b read=%b addr=%h exp v=0 read=1 addr=000c", fetch_valid, instr_read, instr_addr);
    end
    tick;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 16'd12 || fetch_instr !== mem_word(16'd12)) begin
      failures++; $display("FAIL rdp_head got v=%b pc=%h exp v=1 pc=000c", fetch_valid, fetch_pc);
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] seq [4];
    seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000; seq[3] = 16'h0001;
    wait_n      = 0;
    fetch_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    fill_exp(16'hFFFE);
    tick;
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_read !== 1'b1 || instr_addr !== seq[i]) begin
        failures++; $display("FAIL wrap_addr step=%0d got addr=%h exp=%h", i, instr_addr, seq[i]);
      end
      tick;
    end
    repeat (3) tick;
  endtask

  task automatic test_random;
    logic          pw;
    logic [AW-1:0] pa;
    logic [AW-1:0] tgt;
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      wait_n      = $urandom_range(0, 2);
      redirect    = ($urandom_range(0, 15) == 0);
      if (redirect) begin
        if ($urandom_range(0, 1) == 1) tgt = AW'($urandom_range(0, 20));
        else                           tgt = 16'hFFF0 + AW'($urandom_range(0, 15));
        redirect_pc = tgt;
        fill_exp(tgt);
      end
      @(negedge clk);
      pw = instr_read && !mem_done;
      pa = instr_addr;
      tick;
      if (pw) begin
        checks++;
        if (instr_read !== 1'b1 || instr_addr !== pa) begin
          failures++; $display("FAIL rnd_hold got read=%b addr=%h exp read=1 addr=%h", instr_read, instr_addr, pa);
        end
      end
      if (!fetch_valid) begin
        checks++;
        if (fetch_instr !== NOP) begin
          failures++; $display("FAIL rnd_nop got=%h exp=%h", fetch_instr, NOP);
        end
      end
    end
    redirect = 1'b0;
    tick;
  endtask

`ifdef INSTR_FETCH_TIMEOUT_EN
  task automatic test_timeout;
    wait_n = 0;
    do_reset(1'b0);
    repeat (6) tick;
    hang        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'd4;
    fill_exp(16'd4);
    tick;
    redirect = 1'b0;
    repeat (15) tick;
    checks++;
    if (fetch_err !== 1'b0 || instr_read !== 1'b1) begin
      failures++; $display("FAIL to_early got err=%b read=%b exp err=0 read=1", fetch_err, instr_read);
    end
    tick;
    checks++;
    if (fetch_err !== 1'b1 || instr_read !== 1'b0) begin
      failures++; $display("FAIL to_fire got err=%b read=%b exp err=1 read=0", fetch_err, instr_read);
    end
    repeat (5) tick;
    checks++;
    if (fetch_err !== 1'b1 || instr_read !== 1'b0) begin
      failures++; $display("FAIL to_sticky got err=%b read=%b exp err=1 read=0", fetch_err, instr_read);
    end
    hang        = 1'b0;
    fetch_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'd0;
    fill_exp(16'd0);
    tick;
    redirect = 1'b0;
    checks++;
    if (fetch_err !== 1'b0 || instr_read !== 1'b1 || instr_addr !== 16'd0) begin
      failures++; $display("FAIL to_clear got err=%b read=%b addr=%h exp err=0 read=1 addr=0000", fetch_err, instr_read, instr_addr);
    end
    repeat (3) tick;
    checks++;
    if (fetch_valid !== 1'b1) begin
      failures++; $display("FAIL to_resume got v=%b exp=1", fetch_valid);
    end
  endtask
`endif

  initial begin
    prog_rom[0]  = 30'b000000000000000000000000000110;
    prog_rom[1]  = 30'b000000000000000010000000000000;
    prog_rom[2]  = 30'h00041001;
    prog_rom[3]  = 30'h00082002;
    prog_rom[4]  = 30'h000C3003;
    prog_rom[5]  = 30'h01104004;
    prog_rom[6]  = 30'h01505005;
    prog_rom[7]  = 30'h02206006;
    prog_rom[8]  = 30'h02A07007;
    prog_rom[9]  = 30'h03308008;
    prog_rom[10] = 30'h04409009;
    prog_rom[11] = 30'h0550A00A;
    prog_rom[12] = 30'h0660B00B;
    prog_rom[13] = 30'h0770C00C;
    prog_rom[14] = 30'h0880D00D;
    prog_rom[15] = 30'h0990E00E;

    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_drop();
    test_redirect_done_pop();
    test_wrap();
    test_random();
`ifdef INSTR_FETCH_TIMEOUT_EN
    test_timeout();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
